// File: rtl/dram_write_packer_if.sv
// Bundle of the command, token, config and data handshakes around the DRAM
// write packer. The slave view is the packer; the master view is the
// surrounding logic (command/token source plus the AXI write master).
interface dram_write_packer_if #(
    parameter int IN_W = 8
) ();
    logic            CMD_VALID;
    logic            CMD_READY;
    logic [31:0]     CMD_ADDR;
    logic [31:0]     CMD_NBYTES;
    logic [IN_W-1:0] IN_DATA;
    logic            IN_VALID;
    logic            IN_READY;
    logic            OUT_CONFIG_VALID;
    logic            OUT_CONFIG_READY;
    logic [31:0]     OUT_CONFIG_START_ADDR;
    logic [31:0]     OUT_CONFIG_NBYTES;
    logic [63:0]     OUT_DATA;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic            BUSY;

    modport master (
        output CMD_VALID, CMD_ADDR, CMD_NBYTES, IN_DATA, IN_VALID,
               OUT_CONFIG_READY, OUT_READY,
        input  CMD_READY, IN_READY, OUT_CONFIG_VALID, OUT_CONFIG_START_ADDR,
               OUT_CONFIG_NBYTES, OUT_DATA, OUT_VALID, BUSY
    );

    modport slave (
        input  CMD_VALID, CMD_ADDR, CMD_NBYTES, IN_DATA, IN_VALID,
               OUT_CONFIG_READY, OUT_READY,
        output CMD_READY, IN_READY, OUT_CONFIG_VALID, OUT_CONFIG_START_ADDR,
               OUT_CONFIG_NBYTES, OUT_DATA, OUT_VALID, BUSY
    );
endinterface

// File: rtl/dram_write_packer.sv
// Packs a narrow token stream into 64-bit little-endian words for the AXI
// DRAM write master, rounds each frame up to whole 128-byte bursts, issues
// the config handshake and zero-pads the tail of the last burst.
module dram_write_packer #(
    parameter int IN_W = 8
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    dram_write_packer_if.slave bus
);
    localparam int LANES  = 64 / IN_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TOK_SH = $clog2(IN_W / 8);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONFIG = 2'd1;
    localparam logic [1:0] S_PACK   = 2'd2;
    localparam logic [1:0] S_PAD    = 2'd3;

    logic [1:0]        state;
    logic [31:0]       addr_q;
    logic [31:0]       rnd_q;
    logic [31:0]       tok_left;
    logic [31:0]       words_left;
    logic [LANE_W-1:0] lane;
    logic [63:0]       asm_q;
    logic [63:0]       out_data_q;
    logic              out_valid_q;

    logic [32:0]       rnd_wide;
    logic [31:0]       tok_cmd;
    logic [31:0]       tok_nxt;
    logic [LANE_W-1:0] lane_nxt;
    logic [63:0]       word_next;
    logic [63:0]       load_data;
    logic              cmd_fire;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;
    logic              out_free;
    logic              word_done;
    logic              pack_load;
    logic              flush_load;
    logic              pad_load;
    logic              load;

    assign bus.CMD_READY             = (state == S_IDLE);
    assign bus.IN_READY              = in_ready;
    assign bus.OUT_CONFIG_VALID      = (state == S_CONFIG);
    assign bus.OUT_CONFIG_START_ADDR = addr_q;
    assign bus.OUT_CONFIG_NBYTES     = rnd_q;
    assign bus.OUT_DATA              = out_data_q;
    assign bus.OUT_VALID             = out_valid_q;
    assign bus.BUSY                  = (state != S_IDLE);

    // Command decode: token count (sub-token remainder dropped) and the
    // byte count rounded up to the next 128-byte burst boundary.
    assign tok_cmd  = bus.CMD_NBYTES >> TOK_SH;
    assign rnd_wide = ({1'b0, bus.CMD_NBYTES} + 33'd127) & ~33'd127;

    assign cmd_fire = bus.CMD_VALID && (state == S_IDLE);
    assign out_fire = out_valid_q && bus.OUT_READY;
    assign out_free = !out_valid_q || bus.OUT_READY;
    assign in_ready = (state == S_PACK) && (tok_left != 32'd0) &&
                      ((lane != LAST_LANE) || out_free);
    assign in_fire  = bus.IN_VALID && in_ready;

    // A word is complete on its top lane or on the frame's last token. A
    // last token in a lower lane may arrive while the output is stalled;
    // that partial word then waits in the assembly register (flush_load).
    assign word_done  = (lane == LAST_LANE) || (tok_left == 32'd1);
    assign pack_load  = in_fire && word_done && out_free;
    assign flush_load = (state == S_PACK) && (tok_left == 32'd0) &&
                        (lane != '0) && out_free;
    assign pad_load   = (state == S_PAD) && out_free &&
                        (out_valid_q ? (words_left > 32'd1) : (words_left != 32'd0));
    assign load       = pack_load || flush_load || pad_load;

    // Merge the incoming token into its lane of the assembly word.
    always_comb begin
        word_next = asm_q;
        word_next[int'(lane) * IN_W +: IN_W] = bus.IN_DATA;
    end

    // Select what enters the output register: zero pad, deferred partial
    // word, or the freshly completed word.
    always_comb begin
        if (state == S_PAD) begin
            load_data = '0;
        end else if (flush_load) begin
            load_data = asm_q;
        end else begin
            load_data = word_next;
        end
    end

    // Next-cycle token and lane counts, used by both counters and the FSM.
    always_comb begin
        tok_nxt = in_fire ? (tok_left - 32'd1) : tok_left;
        if (pack_load || flush_load) begin
            lane_nxt = '0;
        end else if (in_fire) begin
            lane_nxt = lane + 1'b1;
        end else begin
            lane_nxt = lane;
        end
    end

    // Frame control: state machine, latched command and progress counters.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            rnd_q      <= '0;
            tok_left   <= '0;
            words_left <= '0;
            lane       <= '0;
        end else begin
            lane <= lane_nxt;
            if (cmd_fire) begin
                addr_q     <= bus.CMD_ADDR;
                rnd_q      <= rnd_wide[31:0];
                tok_left   <= tok_cmd;
                words_left <= {3'b000, rnd_wide[31:3]};
            end else begin
                tok_left <= tok_nxt;
                if (out_fire) begin
                    words_left <= words_left - 32'd1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (cmd_fire && (tok_cmd != 32'd0)) begin
                        state <= S_CONFIG;
                    end
                end
                S_CONFIG: begin
                    if (bus.OUT_CONFIG_READY) begin
                        state <= S_PACK;
                    end
                end
                default: begin
                    if (out_fire && (words_left == 32'd1)) begin
                        state <= S_IDLE;
                    end else if ((state == S_PACK) && (tok_nxt == 32'd0) &&
                                 (lane_nxt == '0)) begin
                        state <= S_PAD;
                    end
                end
            endcase
        end
    end

    // Data path: assembly register and single-entry output register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (pack_load || flush_load) begin
                asm_q <= '0;
            end else if (in_fire) begin
                asm_q <= word_next;
            end
            if (load) begin
                out_data_q  <= load_data;
                out_valid_q <= 1'b1;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule
